// File: rtl/mips_pkg.sv
// Shared opcodes, FSM states and access-size encoding for the MIPS32 memory stage.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic {IDLE, WAIT} state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        pc_to_reg;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] alu_res;
    logic [31:0] mem_data;
    logic [4:0]  write_addr;
    logic        exc_misalign;
    logic        bus_err;
  } memwb_t;

endpackage

// File: rtl/mem_align.sv
// Size/sign decode, alignment check, store lane formatting and load extension (little-endian).
module mem_align
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic        mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        misalign,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  size_e       size;
  logic        is_unsigned;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    size        = SZ_W;
    is_unsigned = 1'b0;
    case (opcode)
      OP_LB, OP_SB: size = SZ_B;
      OP_LBU: begin
        size        = SZ_B;
        is_unsigned = 1'b1;
      end
      OP_LH, OP_SH: size = SZ_H;
      OP_LHU: begin
        size        = SZ_H;
        is_unsigned = 1'b1;
      end
      default: size = SZ_W;
    endcase
  end

  assign byte_lane = rdata[{addr[1:0], 3'b000} +: 8];
  assign half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

  assign misalign = mem_op & (((size == SZ_H) & addr[0]) |
                              ((size == SZ_W) & (addr[1:0] != 2'b00)));

  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr[1:0];
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{~is_unsigned & byte_lane[7]}}, byte_lane};
      end
      SZ_H: begin
        be        = addr[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{~is_unsigned & half_lane[15]}}, half_lane};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory handshake FSM with timeout, stall generation and MEM/WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_read,
  input  logic        imem_write,
  input  logic        imem_to_reg,
  input  logic        ipc_to_reg,
  input  logic        ireg_write,
  input  logic [31:0] iPC,
  input  logic [31:0] iIR,
  input  logic [31:0] ialu_res,
  input  logic [31:0] iData_forMem,
  input  logic [4:0]  iwrite_addr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall,
  output logic        oreg_write,
  output logic        omem_to_reg,
  output logic        opc_to_reg,
  output logic [31:0] oPC,
  output logic [31:0] oIR,
  output logic [31:0] oalu_res,
  output logic [31:0] omem_data,
  output logic [4:0]  owrite_addr,
  output logic        oexc_misalign,
  output logic        obus_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  memwb_t          wb_q, wb_d;

  logic        mem_op;
  logic        misalign;
  logic        timeout_hit;
  logic [31:0] load_data;

  assign mem_op = imem_read | imem_write;

  mem_align u_align (
    .opcode     (iIR[31:26]),
    .mem_op     (mem_op),
    .addr       (ialu_res),
    .store_data (iData_forMem),
    .rdata      (dmem_rdata),
    .misalign   (misalign),
    .be         (dmem_be),
    .wdata      (dmem_wdata),
    .load_data  (load_data)
  );

  assign dmem_req    = ~reset & mem_op & ~misalign;
  assign dmem_we     = dmem_req & imem_write;
  assign dmem_addr   = {ialu_res[31:2], 2'b00};
  // Ready on the final wait cycle still completes the access.
  assign timeout_hit = (state_q == WAIT) & (cnt_q == TimeoutCnt) & ~dmem_ready;
  assign stall       = dmem_req & ~dmem_ready & ~timeout_hit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (dmem_req && !dmem_ready) begin
          state_d = WAIT;
          cnt_d   = CntW'(1);
        end
      end
      WAIT: begin
        if (!dmem_req || dmem_ready || timeout_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A stalled cycle leaves wb_d at all-zero, i.e. a bubble.
  always_comb begin
    wb_d = '0;
    if (!stall) begin
      wb_d.reg_write  = ireg_write;
      wb_d.mem_to_reg = imem_to_reg;
      wb_d.pc_to_reg  = ipc_to_reg;
      wb_d.pc         = iPC;
      wb_d.ir         = iIR;
      wb_d.alu_res    = ialu_res;
      wb_d.write_addr = iwrite_addr;
      if (misalign) begin
        wb_d.reg_write    = 1'b0;
        wb_d.exc_misalign = 1'b1;
      end else if (timeout_hit) begin
        wb_d.reg_write = 1'b0;
        wb_d.bus_err   = 1'b1;
      end else if (imem_read) begin
        wb_d.mem_data = load_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
    end
  end

  assign oreg_write    = wb_q.reg_write;
  assign omem_to_reg   = wb_q.mem_to_reg;
  assign opc_to_reg    = wb_q.pc_to_reg;
  assign oPC           = wb_q.pc;
  assign oIR           = wb_q.ir;
  assign oalu_res      = wb_q.alu_res;
  assign omem_data     = wb_q.mem_data;
  assign owrite_addr   = wb_q.write_addr;
  assign oexc_misalign = wb_q.exc_misalign;
  assign obus_err      = wb_q.bus_err;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage: loads, stores, waits, misalignment, timeout, reset.
module tb_mem_stage;
  import mips_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_read, imem_write, imem_to_reg, ipc_to_reg, ireg_write;
  logic [31:0] iPC, iIR, ialu_res, iData_forMem;
  logic [4:0]  iwrite_addr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic        stall;
  logic        oreg_write, omem_to_reg, opc_to_reg;
  logic [31:0] oPC, oIR, oalu_res, omem_data;
  logic [4:0]  owrite_addr;
  logic        oexc_misalign, obus_err;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clock = ~clock;

  mem_stage #(.TIMEOUT(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_read     (imem_read),
    .imem_write    (imem_write),
    .imem_to_reg   (imem_to_reg),
    .ipc_to_reg    (ipc_to_reg),
    .ireg_write    (ireg_write),
    .iPC           (iPC),
    .iIR           (iIR),
    .ialu_res      (ialu_res),
    .iData_forMem  (iData_forMem),
    .iwrite_addr   (iwrite_addr),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wdata    (dmem_wdata),
    .dmem_be       (dmem_be),
    .dmem_rdata    (dmem_rdata),
    .dmem_ready    (dmem_ready),
    .stall         (stall),
    .oreg_write    (oreg_write),
    .omem_to_reg   (omem_to_reg),
    .opc_to_reg    (opc_to_reg),
    .oPC           (oPC),
    .oIR           (oIR),
    .oalu_res      (oalu_res),
    .omem_data     (omem_data),
    .owrite_addr   (owrite_addr),
    .oexc_misalign (oexc_misalign),
    .obus_err      (obus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ir_of(input logic [5:0] op);
    return {op, 5'd4, 5'd9, 16'h0010};
  endfunction

  task automatic set_mem(input logic [5:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] pc);
    imem_read    = (op[5:3] == 3'b100);
    imem_write   = (op[5:3] == 3'b101);
    imem_to_reg  = (op[5:3] == 3'b100);
    ipc_to_reg   = 1'b0;
    ireg_write   = (op[5:3] == 3'b100);
    iPC          = pc;
    iIR          = ir_of(op);
    ialu_res     = addr;
    iData_forMem = sdata;
    iwrite_addr  = 5'd9;
  endtask

  task automatic set_add();
    imem_read    = 1'b0;
    imem_write   = 1'b0;
    imem_to_reg  = 1'b0;
    ipc_to_reg   = 1'b0;
    ireg_write   = 1'b1;
    iPC          = 32'h0000_0500;
    iIR          = 32'h0109_4020;
    ialu_res     = 32'h0000_1234;
    iData_forMem = 32'h0;
    iwrite_addr  = 5'd8;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset      = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    set_mem(OP_LW, 32'h100, 32'h0, 32'h40);
    #1;
    check("req_forced_low_in_reset", {31'b0, dmem_req}, 32'h0);
    tick();
    tick();
    check("rst_oreg_write", {31'b0, oreg_write}, 32'h0);
    check("rst_oIR", oIR, 32'h0);
    check("rst_oPC", oPC, 32'h0);
    check("rst_omem_data", omem_data, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    reset = 1'b0;

    // lw 0x100, zero-wait
    set_mem(OP_LW, 32'h100, 32'h0, 32'h40);
    dmem_rdata = 32'hDEAD_BEEF;
    dmem_ready = 1'b1;
    #1;
    check("lw_req", {31'b0, dmem_req}, 32'h1);
    check("lw_stall", {31'b0, stall}, 32'h0);
    check("lw_addr", dmem_addr, 32'h100);
    check("lw_be", {28'b0, dmem_be}, 32'hF);
    check("lw_we", {31'b0, dmem_we}, 32'h0);
    tick();
    check("lw_data", omem_data, 32'hDEAD_BEEF);
    check("lw_oreg_write", {31'b0, oreg_write}, 32'h1);
    check("lw_omem_to_reg", {31'b0, omem_to_reg}, 32'h1);
    check("lw_oPC", oPC, 32'h40);
    check("lw_owrite_addr", {27'b0, owrite_addr}, 32'd9);

    // Sub-word loads
    dmem_rdata = 32'h8011_2233;
    set_mem(OP_LB, 32'h103, 32'h0, 32'h44);
    tick();
    check("lb_103", omem_data, 32'hFFFF_FF80);
    set_mem(OP_LBU, 32'h103, 32'h0, 32'h48);
    tick();
    check("lbu_103", omem_data, 32'h0000_0080);
    set_mem(OP_LH, 32'h102, 32'h0, 32'h4C);
    tick();
    check("lh_102", omem_data, 32'hFFFF_8011);
    set_mem(OP_LHU, 32'h100, 32'h0, 32'h50);
    tick();
    check("lhu_100", omem_data, 32'h0000_2233);

    // sb formatting
    set_mem(OP_SB, 32'h201, 32'h0000_0012, 32'h54);
    #1;
    check("sb_be", {28'b0, dmem_be}, 32'h2);
    check("sb_wdata", dmem_wdata, 32'h1212_1212);
    tick();

    // sh 0x202 with 3 wait cycles
    dmem_ready = 1'b0;
    set_mem(OP_SH, 32'h202, 32'h0000_ABCD, 32'h60);
    #1;
    check("sh_be", {28'b0, dmem_be}, 32'hC);
    check("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    check("sh_addr", dmem_addr, 32'h200);
    check("sh_we", {31'b0, dmem_we}, 32'h1);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall) n++;
      tick();
      check("sh_bubble_oIR", oIR, 32'h0);
      check("sh_bubble_oreg_write", {31'b0, oreg_write}, 32'h0);
    end
    dmem_ready = 1'b1;
    #1;
    check("sh_stall_on_ready", {31'b0, stall}, 32'h0);
    check("sh_stall_cycles", n, 32'd3);
    tick();
    check("sh_done_oIR", oIR, ir_of(OP_SH));
    check("sh_done_oreg_write", {31'b0, oreg_write}, 32'h0);
    check("sh_done_oPC", oPC, 32'h60);

    // add with stray ready
    set_add();
    #1;
    check("add_req", {31'b0, dmem_req}, 32'h0);
    check("add_stall", {31'b0, stall}, 32'h0);
    tick();
    check("add_alu", oalu_res, 32'h1234);
    check("add_oreg_write", {31'b0, oreg_write}, 32'h1);
    check("add_omem_data", omem_data, 32'h0);
    check("add_oIR", oIR, 32'h0109_4020);

    // Misaligned lw
    dmem_ready = 1'b0;
    set_mem(OP_LW, 32'h101, 32'h0, 32'h64);
    #1;
    check("mis_req", {31'b0, dmem_req}, 32'h0);
    check("mis_stall", {31'b0, stall}, 32'h0);
    tick();
    check("mis_exc", {31'b0, oexc_misalign}, 32'h1);
    check("mis_oreg_write", {31'b0, oreg_write}, 32'h0);
    check("mis_oIR", oIR, ir_of(OP_LW));
    set_add();
    tick();
    check("mis_exc_drop", {31'b0, oexc_misalign}, 32'h0);

    // Timeout
    set_mem(OP_LW, 32'h300, 32'h0, 32'h70);
    #1;
    n = 0;
    while (stall && n < 40) begin
      n++;
      tick();
    end
    check("to_stall_cycles", n, 32'd16);
    tick();
    check("to_bus_err", {31'b0, obus_err}, 32'h1);
    check("to_oreg_write", {31'b0, oreg_write}, 32'h0);
    check("to_oPC", oPC, 32'h70);
    set_add();
    tick();
    check("to_bus_err_drop", {31'b0, obus_err}, 32'h0);
    check("to_add_after", {31'b0, oreg_write}, 32'h1);

    // Reset during 2nd wait cycle
    set_mem(OP_LW, 32'h400, 32'h0, 32'h80);
    tick();
    tick();
    check("rw_stall_in_wait", {31'b0, stall}, 32'h1);
    reset = 1'b1;
    #1;
    check("rw_req_forced", {31'b0, dmem_req}, 32'h0);
    tick();
    reset = 1'b0;
    set_add();
    #1;
    check("rw_oreg_write", {31'b0, oreg_write}, 32'h0);
    check("rw_oIR", oIR, 32'h0);
    check("rw_oPC", oPC, 32'h0);
    check("rw_obus_err", {31'b0, obus_err}, 32'h0);
    check("rw_req", {31'b0, dmem_req}, 32'h0);
    check("rw_stall", {31'b0, stall}, 32'h0);
    tick();
    check("rw_add_oreg_write", {31'b0, oreg_write}, 32'h1);
    check("rw_add_alu", oalu_res, 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
